// File: rtl/lb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lb_pkg : shared types and constants for the line-buffer controller   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } lb_state_t;

    localparam int c_KERNEL_DEFAULT = 3;

endpackage
`default_nettype wire

// File: rtl/lb_pos_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lb_pos_counter : column/row position of the next pixel in a frame    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lb_pos_counter #(
    parameter int IMG_WIDTH  = 10,
    parameter int IMG_HEIGHT = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          inc,
    input  logic                          clr,
    output logic [$clog2(IMG_WIDTH)-1:0]  col,
    output logic [$clog2(IMG_HEIGHT)-1:0] row,
    output logic                          last
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] c_COL_MAX = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] c_ROW_MAX = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          w_last;

    assign w_last = (r_col == c_COL_MAX) && (r_row == c_ROW_MAX);

    // Saturates on the final pixel of the frame; only clr restarts it.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (inc && !w_last) begin
            if (r_col == c_COL_MAX) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign col  = r_col;
    assign row  = r_row;
    assign last = w_last;

endmodule
`default_nettype wire

// File: rtl/line_buffer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | line_buffer_ctrl : shift/window sequencing for a line-buffer chain   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module line_buffer_ctrl
    import lb_pkg::*;
#(
    parameter int IMG_WIDTH  = 10,
    parameter int IMG_HEIGHT = 10,
    parameter int KERNEL     = c_KERNEL_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          shift_en,
    output logic                          win_valid,
    input  logic                          win_ready,
    output logic [$clog2(IMG_WIDTH)-1:0]  col_idx,
    output logic [$clog2(IMG_HEIGHT)-1:0] row_idx,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    lb_state_t     r_state;
    lb_state_t     w_state_nxt;
    logic          r_win_valid;
    logic          r_frame_end;
    logic [CW-1:0] r_col_idx;
    logic [RW-1:0] r_row_idx;

    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic          w_last;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_start_frame;
    logic          w_win_pix;

    // w_col/w_row is the position of the pixel being offered this cycle.
    lb_pos_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_pos (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_accept),
        .clr  (w_start_frame),
        .col  (w_col),
        .row  (w_row),
        .last (w_last)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_in_ready    = 1'b0;
        w_start_frame = 1'b0;

        if ((r_state == ST_FILL || r_state == ST_STREAM) && !r_frame_end)
            w_in_ready = !r_win_valid || win_ready;
        w_accept  = in_valid && w_in_ready;
        w_win_pix = (w_row >= RW'(KERNEL - 1)) && (w_col >= CW'(KERNEL - 1));

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_start_frame = 1'b1;
                    w_state_nxt   = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_accept && w_row == RW'(KERNEL - 1) && w_col == '0)
                    w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                // Last pixel is always window-producing, so wait for that window to drain.
                if (r_frame_end && (!r_win_valid || win_ready))
                    w_state_nxt = ST_DONE;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_win_valid <= 1'b0;
            r_frame_end <= 1'b0;
            r_col_idx   <= '0;
            r_row_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_frame) begin
                r_win_valid <= 1'b0;
                r_frame_end <= 1'b0;
                r_col_idx   <= '0;
                r_row_idx   <= '0;
            end else begin
                if (w_accept) begin
                    r_col_idx <= w_col;
                    r_row_idx <= w_row;
                    if (w_last)
                        r_frame_end <= 1'b1;
                end
                if (w_accept && w_win_pix)
                    r_win_valid <= 1'b1;
                else if (r_win_valid && win_ready)
                    r_win_valid <= 1'b0;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign shift_en   = w_accept;
    assign win_valid  = r_win_valid;
    assign col_idx    = r_col_idx;
    assign row_idx    = r_row_idx;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_line_buffer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_line_buffer_ctrl : self-checking bench for line_buffer_ctrl       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_line_buffer_ctrl;

    localparam int W  = 10;
    localparam int H  = 10;
    localparam int K  = 3;
    localparam int WX = W - K + 1;

    logic       clk;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic       shift_en;
    logic       win_valid;
    logic       win_ready;
    logic [3:0] col_idx;
    logic [3:0] row_idx;
    logic       busy;
    logic       frame_done;

    line_buffer_ctrl #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .KERNEL     (K)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .shift_en   (shift_en),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .col_idx    (col_idx),
        .row_idx    (row_idx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame monitor: independent pixel/window model driven only by observed handshakes.
    bit mon_en = 1'b0;
    bit wv_prev;
    int acc, wins, fdone, rises, first_win_acc;
    int exp_r, exp_c;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_r = (acc == 0) ? 0 : (acc - 1) / W;
            exp_c = (acc == 0) ? 0 : (acc - 1) % W;
            chk("row_idx_track", int'(row_idx), exp_r);
            chk("col_idx_track", int'(col_idx), exp_c);
            if (win_valid && !wv_prev) rises++;
            if (win_valid && first_win_acc < 0) first_win_acc = acc;
            if (win_valid && win_ready) begin
                chk("win_order_row", int'(row_idx), K - 1 + wins / WX);
                chk("win_order_col", int'(col_idx), K - 1 + wins % WX);
                wins++;
            end
            if (shift_en) begin
                if (!in_valid) chk("shift_without_valid", 1, 0);
                acc++;
            end
            if (frame_done) fdone++;
            wv_prev = win_valid;
        end
    end

    typedef struct {
        int rst, start, iv, wr;
        int ir, se, wv, bz, fd, col, row;
    } vec_t;

    vec_t vecs[13];

    task automatic run_frame(input bit toggle, input bit stall, input int start_at,
                             input int rst_at);
        int  stall_left = 0;
        bit  stalled    = 1'b0;
        bit  started    = 1'b0;
        bit  done       = 1'b0;
        acc = 0; wins = 0; fdone = 0; rises = 0; first_win_acc = -1; wv_prev = 1'b0;
        rst = 1'b0; start = 1'b1; in_valid = 1'b0; win_ready = 1'b1;
        step();
        start  = 1'b0;
        mon_en = 1'b1;
        for (int n = 0; n < 1000 && !done; n++) begin
            in_valid  = toggle ? ((n % 2) == 0) : 1'b1;
            win_ready = 1'b1;
            start     = 1'b0;
            if (stall && !stalled && win_valid) begin
                stalled    = 1'b1;
                stall_left = 5;
            end
            if (stall_left > 0) win_ready = 1'b0;
            if (start_at >= 0 && !started && acc == start_at) begin
                start   = 1'b1;
                started = 1'b1;
            end
            if (rst_at >= 0 && acc == rst_at) begin
                rst    = 1'b1;
                mon_en = 1'b0;
            end
            @(negedge clk);
            if (stall_left > 0) begin
                chk("stall_in_ready", int'(in_ready), 0);
                chk("stall_shift_en", int'(shift_en), 0);
                chk("stall_col_row", int'({row_idx, col_idx}), 8'h22);
                stall_left--;
            end
            if (frame_done) done = 1'b1;
            @(posedge clk);
            #1;
            if (rst) begin
                rst = 1'b0;
                @(negedge clk);
                chk("rst_mid_outputs",
                    int'({in_ready, shift_en, win_valid, busy, frame_done}), 0);
                chk("rst_mid_col_row", int'({row_idx, col_idx}), 0);
                in_valid = 1'b0;
                step();
                return;
            end
        end
        if (!done) chk("frame_timeout", 0, 1);
        start    = 1'b0;
        in_valid = 1'b1;
        repeat (3) step();
        mon_en   = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //          rst st iv wr | ir se wv bz fd col row
        vecs[0]  = '{1, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 1, 1,  1, 1, 0, 1, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 1,  1, 0, 0, 1, 0, 0, 0};
        vecs[5]  = '{0, 1, 1, 1,  1, 1, 0, 1, 0, 0, 0};
        vecs[6]  = '{0, 0, 1, 0,  1, 1, 0, 1, 0, 1, 0};
        vecs[7]  = '{1, 1, 1, 1,  1, 1, 0, 1, 0, 2, 0};
        vecs[8]  = '{0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0};
        vecs[9]  = '{0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0};
        vecs[11] = '{1, 0, 0, 1,  1, 0, 0, 1, 0, 0, 0};
        vecs[12] = '{0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; win_ready = 1'b0;
        step();
        step();

        for (int i = 0; i < 13; i++) begin
            rst       = vecs[i].rst[0];
            start     = vecs[i].start[0];
            in_valid  = vecs[i].iv[0];
            win_ready = vecs[i].wr[0];
            @(negedge clk);
            chk($sformatf("vec%0d_flags", i),
                int'({in_ready, shift_en, win_valid, busy, frame_done}),
                (vecs[i].ir << 4) | (vecs[i].se << 3) | (vecs[i].wv << 2) |
                (vecs[i].bz << 1) | vecs[i].fd);
            chk($sformatf("vec%0d_col", i), int'(col_idx), vecs[i].col);
            chk($sformatf("vec%0d_row", i), int'(row_idx), vecs[i].row);
            step();
        end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; win_ready = 1'b1;
        step();

        // Continuous streaming.
        run_frame(1'b0, 1'b0, -1, -1);
        chk("norm_first_win_acc", first_win_acc, 23);
        chk("norm_windows", wins, WX * (H - K + 1));
        chk("norm_accepts", acc, W * H);
        chk("norm_frame_done", fdone, 1);
        chk("norm_win_rises", rises, H - K + 1);

        // Downstream stall at the first window.
        run_frame(1'b0, 1'b1, -1, -1);
        chk("stall_windows", wins, 64);
        chk("stall_accepts", acc, 100);
        chk("stall_frame_done", fdone, 1);

        // in_valid toggling every cycle.
        run_frame(1'b1, 1'b0, -1, -1);
        chk("tog_accepts", acc, 100);
        chk("tog_windows", wins, 64);
        chk("tog_frame_done", fdone, 1);
        chk("tog_win_rises", rises, 64);

        // start mid-frame is ignored.
        run_frame(1'b0, 1'b0, 40, -1);
        chk("restart_windows", wins, 64);
        chk("restart_accepts", acc, 100);
        chk("restart_frame_done", fdone, 1);

        // Reset mid-frame, then a full frame.
        run_frame(1'b0, 1'b0, -1, 57);
        chk("rst_no_frame_done", fdone, 0);
        run_frame(1'b0, 1'b0, -1, -1);
        chk("post_rst_windows", wins, 64);
        chk("post_rst_accepts", acc, 100);
        chk("post_rst_frame_done", fdone, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
